// File: rtl/ask_fsk_demod_if.sv
// ask_fsk_demod_if: sample input and recovered timing/data outputs of the ASK/FSK demodulator.
// DEMOD_SYMCNT_EN adds the sym_cnt symbol counter.
interface ask_fsk_demod_if #(
  parameter int CNT_W  = 6,
  parameter int SAMP_W = 8
);
  logic                     en;
  logic                     mode;
  logic signed [SAMP_W-1:0] sample;
  logic [CNT_W-1:0]         cnt;
  logic                     p;
  logic                     s;
  logic                     sync;
  logic                     bit_out;
  logic                     bit_valid;
`ifdef DEMOD_SYMCNT_EN
  logic [7:0]               sym_cnt;
  modport master (output en, mode, sample, input cnt, p, s, sync, bit_out, bit_valid, sym_cnt);
  modport slave  (input en, mode, sample, output cnt, p, s, sync, bit_out, bit_valid, sym_cnt);
`else
  modport master (output en, mode, sample, input cnt, p, s, sync, bit_out, bit_valid);
  modport slave  (input en, mode, sample, output cnt, p, s, sync, bit_out, bit_valid);
`endif
endinterface

// File: rtl/ask_fsk_demod.sv
// ask_fsk_demod: locks to the first rising zero crossing, rebuilds A/B/C/D symbol timing, decides one bit per symbol.
// Optional DEMOD_SYMCNT_EN adds a saturating count of decided symbols.
module ask_fsk_demod #(
  parameter int CNT_W           = 6,
  parameter int SAMP_W          = 8,
  parameter int ASK_THRESH      = 8192,
  parameter int FSK_EDGE_THRESH = 4
) (
  input logic             clk,
  input logic             rst,
  ask_fsk_demod_if.slave  bus
);
  localparam int ACC_W = SAMP_W + CNT_W + 2;
  localparam int EDG_W = CNT_W + 2;
  typedef enum logic {HUNT, ACC} state_t;
  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [1:0]        r_phase, w_phase;
  logic [ACC_W-1:0]  r_acc, w_acc, w_acc_sum;
  logic [EDG_W-1:0]  r_edges, w_edges, w_edges_sum;
  logic              r_prev_neg, w_prev_neg, r_bit, w_bit, r_valid, w_valid;
  logic              w_neg, w_rise, w_end;
  logic [SAMP_W:0]   w_abs;
`ifdef DEMOD_SYMCNT_EN
  logic [7:0]        r_sym, w_sym;
`endif
  always_comb begin
    w_neg       = bus.sample[SAMP_W-1];
    w_rise      = r_prev_neg & ~w_neg;
    // one extra bit so |most negative| is representable
    w_abs       = w_neg ? ~{1'b1, bus.sample} + 1'b1 : {1'b0, bus.sample};
    w_acc_sum   = r_acc + ACC_W'(w_abs);
    w_edges_sum = r_edges + EDG_W'(w_rise);
    w_end       = (r_state == ACC) && (r_phase == 2'd3) && (&r_cnt);
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_phase     = r_phase;
    w_acc       = r_acc;
    w_edges     = r_edges;
    w_prev_neg  = w_neg;
    w_bit       = r_bit;
    w_valid     = 1'b0;
    if (!bus.en) begin
      w_state    = HUNT;
      w_cnt      = '0;
      w_phase    = '0;
      w_acc      = '0;
      w_edges    = '0;
      w_prev_neg = 1'b0;
    end else if (r_state == HUNT) begin
      if (w_rise) begin
        w_state = ACC;
        w_cnt   = CNT_W'(1);
        w_phase = '0;
        w_acc   = ACC_W'(w_abs);
        w_edges = EDG_W'(1);
      end
    end else begin
      w_cnt   = r_cnt + 1'b1;
      w_phase = (&r_cnt) ? r_phase + 1'b1 : r_phase;
      w_acc   = w_end ? '0 : w_acc_sum;
      w_edges = w_end ? '0 : w_edges_sum;
      w_valid = w_end;
      w_bit   = !w_end ? r_bit :
                bus.mode ? (w_edges_sum >= EDG_W'(FSK_EDGE_THRESH)) : (w_acc_sum > ACC_W'(ASK_THRESH));
    end
`ifdef DEMOD_SYMCNT_EN
    w_sym = !bus.en ? 8'd0 : (w_valid && r_sym != 8'hFF) ? r_sym + 8'd1 : r_sym;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_acc      <= '0;
      r_edges    <= '0;
      r_prev_neg <= 1'b0;
      r_bit      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_phase    <= w_phase;
      r_acc      <= w_acc;
      r_edges    <= w_edges;
      r_prev_neg <= w_prev_neg;
      r_bit      <= w_bit;
      r_valid    <= w_valid;
    end
  end
`ifdef DEMOD_SYMCNT_EN
  always_ff @(posedge clk) r_sym <= !rst ? 8'd0 : w_sym;
  assign bus.sym_cnt = r_sym;
`endif
  assign bus.cnt       = r_cnt;
  assign bus.p         = r_phase[0];
  assign bus.s         = r_phase[1];
  assign bus.sync      = (r_state == ACC);
  assign bus.bit_out   = r_bit;
  assign bus.bit_valid = r_valid;
endmodule
